// File: rtl/alu_ui_pkg.sv
// -----------------------------------------------------------------------------
// alu_ui_pkg
// Shared definitions for the ALU operand loader front-end.
// Holds the chord FSM state encoding, the recognised chord masks and the
// opcode width.
// -----------------------------------------------------------------------------
package alu_ui_pkg;

    localparam int NUM_BTN = 6;
    localparam int OP_W    = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        ACT     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Chord masks, bit 5 is the leftmost button
    localparam logic [NUM_BTN-1:0] MASK_A      = 6'b100000;
    localparam logic [NUM_BTN-1:0] MASK_B      = 6'b010000;
    localparam logic [NUM_BTN-1:0] MASK_OP     = 6'b001000;
    localparam logic [NUM_BTN-1:0] MASK_SHOW_A = 6'b000100;
    localparam logic [NUM_BTN-1:0] MASK_SHOW_B = 6'b000010;
    localparam logic [NUM_BTN-1:0] MASK_SHOW_F = 6'b000001;
    localparam logic [NUM_BTN-1:0] MASK_CLR    = 6'b000110;
    localparam logic [NUM_BTN-1:0] MASK_ACC    = 6'b100001;

    // True for the chords that only change the display select
    function automatic logic is_show_chord(input logic [NUM_BTN-1:0] mask);
        return (mask == MASK_SHOW_A) || (mask == MASK_SHOW_B) || (mask == MASK_SHOW_F);
    endfunction

endpackage

// File: rtl/alu_operand_loader_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One push-button channel: 2-flop synchroniser followed by a stability
// counter. The debounced bit only flips after the synchronised input has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles; any agreement
// restarts the count. Raw-to-debounced latency is DEBOUNCE_CYCLES+2 cycles.
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   btn_raw in   asynchronous raw button level
//   btn_db  out  debounced button level
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state logic for synchroniser, stability counter and debounced bit
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = cnt_q;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d  = ~db_q;
                cnt_d = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_db = db_q;

endmodule

// File: rtl/alu_operand_loader.sv
// -----------------------------------------------------------------------------
// alu_operand_loader
// Front-end for the board ALU. Debounces six push buttons, collects single
// presses and two-button chords, and latches operand A, operand B and the
// opcode from the slide switches. Every register change is announced by a
// one-cycle upd strobe so the ALU recomputes on a clean clock edge.
//
// Optional feature macro: ALU_ACC_FEEDBACK_EN
//   When defined, adds input f_in (ALU result) and chord 100001 loads it into
//   operand A for accumulator chaining. When undefined, 100001 is an error.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   f_in      in   ALU result (only with ALU_ACC_FEEDBACK_EN)
//   sw        in   slide switches, bit 31 leftmost
//   btn_raw   in   raw push buttons, bit 5 leftmost
//   a_out     out  latched operand A
//   b_out     out  latched operand B
//   op_out    out  latched opcode (sw[31:28] at load time)
//   show_mode out  one-hot display select, 0 = live switches
//   upd       out  one-cycle strobe on any valid decode
//   err       out  one-cycle strobe on an unrecognised chord
//   busy      out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module alu_operand_loader
    import alu_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CHORD_CYCLES    = 2000000,
    parameter int DATA_W          = 32
) (
    input  logic              clk,
    input  logic              rst,
`ifdef ALU_ACC_FEEDBACK_EN
    input  logic [DATA_W-1:0] f_in,
`endif
    input  logic [DATA_W-1:0] sw,
    input  logic [5:0]        btn_raw,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [OP_W-1:0]   op_out,
    output logic [5:0]        show_mode,
    output logic              upd,
    output logic              err,
    output logic              busy
);

    localparam int TMR_W = $clog2(CHORD_CYCLES) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CHORD_CYCLES - 1);

    logic [NUM_BTN-1:0] db;

    state_t             state_q, state_d;
    logic [NUM_BTN-1:0] mask_q, mask_d;
    logic [TMR_W-1:0]   timer_q, timer_d;

    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [NUM_BTN-1:0] show_q, show_d;
    logic               upd_q, upd_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn_debounce (
            .clk    (clk),
            .rst    (rst),
            .btn_raw(btn_raw[i]),
            .btn_db (db[i])
        );
    end

    // State register and all output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= {NUM_BTN{1'b0}};
            timer_q <= {TMR_W{1'b0}};
            a_q     <= {DATA_W{1'b0}};
            b_q     <= {DATA_W{1'b0}};
            op_q    <= {OP_W{1'b0}};
            show_q  <= {NUM_BTN{1'b0}};
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            timer_q <= timer_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            show_q  <= show_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: chord collection and sequencing
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (db != {NUM_BTN{1'b0}}) begin
                    mask_d  = db;
                    timer_d = {TMR_W{1'b0}};
                    state_d = SETTLE;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                mask_d  = mask_q | db;
                timer_d = timer_q + TMR_W'(1);
                // A quick release ends the chord early, otherwise the window closes it
                if ((db == {NUM_BTN{1'b0}}) || (timer_q == TMR_LAST)) begin
                    state_d = ACT;
                end else begin
                    state_d = SETTLE;
                end
            end
            ACT: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                // Presses seen here never reach the mask
                if (db == {NUM_BTN{1'b0}}) begin
                    state_d = IDLE;
                end else begin
                    state_d = RELEASE;
                end
            end
            default: begin
                state_d = IDLE;
                mask_d  = {NUM_BTN{1'b0}};
                timer_d = {TMR_W{1'b0}};
            end
        endcase
    end

    // Output logic: chord decode in ACT, registered on the edge leaving ACT
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        show_d = show_q;
        upd_d  = 1'b0;
        err_d  = 1'b0;
        busy_d = (state_d != IDLE);
        if (state_q == ACT) begin
            case (mask_q)
                MASK_A: begin
                    a_d    = sw;
                    show_d = MASK_A;
                    upd_d  = 1'b1;
                end
                MASK_B: begin
                    b_d    = sw;
                    show_d = MASK_B;
                    upd_d  = 1'b1;
                end
                MASK_OP: begin
                    op_d   = sw[DATA_W-1 -: OP_W];
                    show_d = MASK_OP;
                    upd_d  = 1'b1;
                end
                MASK_CLR: begin
                    show_d = {NUM_BTN{1'b0}};
                    upd_d  = 1'b1;
                end
`ifdef ALU_ACC_FEEDBACK_EN
                MASK_ACC: begin
                    a_d    = f_in;
                    show_d = MASK_A;
                    upd_d  = 1'b1;
                end
`endif
                default: begin
                    if (is_show_chord(mask_q)) begin
                        show_d = mask_q;
                        upd_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end else begin
            upd_d = 1'b0;
            err_d = 1'b0;
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign op_out    = op_q;
    assign show_mode = show_q;
    assign upd       = upd_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_loader
// Directed bench with DEBOUNCE_CYCLES=4 and CHORD_CYCLES=8. A held press
// (20 cycles) raises the debounced bit after 6 cycles, SETTLE runs the full
// 8-cycle window, and the upd/err strobe is seen 16 cycles after the raw edge.
// -----------------------------------------------------------------------------
module tb_alu_operand_loader;

    localparam int DW = 32;
    localparam int STROBE_LAT = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] sw;
    logic [5:0]    btn_raw;
    logic [DW-1:0] a_out, b_out;
    logic [3:0]    op_out;
    logic [5:0]    show_mode;
    logic          upd, err, busy;
`ifdef ALU_ACC_FEEDBACK_EN
    logic [DW-1:0] f_in = 32'h0000_0007;
`endif

    alu_operand_loader #(
        .DEBOUNCE_CYCLES(4),
        .CHORD_CYCLES   (8),
        .DATA_W         (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef ALU_ACC_FEEDBACK_EN
        .f_in     (f_in),
`endif
        .sw       (sw),
        .btn_raw  (btn_raw),
        .a_out    (a_out),
        .b_out    (b_out),
        .op_out   (op_out),
        .show_mode(show_mode),
        .upd      (upd),
        .err      (err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]    btn;
        logic [DW-1:0] sw;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [3:0]    op;
        logic [5:0]    show;
        int            n_upd;
        int            n_err;
    } vec_t;

    vec_t tbl[10];

    int n_vec  = 0;
    int n_miss = 0;
    int rel_cyc;
    int upd_cnt, err_cnt, first_strobe;
    bit busy_seen;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        rel_cyc      = 0;
        upd_cnt      = 0;
        err_cnt      = 0;
        first_strobe = -1;
        busy_seen    = 1'b0;
    endtask

    // One cycle; outputs sampled at the falling edge
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rel_cyc++;
            if (busy) busy_seen = 1'b1;
            if (upd || err) begin
                if (first_strobe < 0) first_strobe = rel_cyc;
                chk("upd_err_exclusive", {31'd0, upd & err}, 32'd0);
            end
            if (upd) upd_cnt++;
            if (err) err_cnt++;
        end
    endtask

    task automatic chk_regs(input string tag, input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                            input logic [3:0] eop, input logic [5:0] eshow);
        chk({tag, ".a_out"}, a_out, ea);
        chk({tag, ".b_out"}, b_out, eb);
        chk({tag, ".op_out"}, {28'd0, op_out}, {28'd0, eop});
        chk({tag, ".show_mode"}, {26'd0, show_mode}, {26'd0, eshow});
    endtask

    initial begin
        // Stimulus table: each row is a 20-cycle press followed by release
        tbl[0] = '{6'b100000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 4'h0, 6'b100000, 1, 0};
        tbl[1] = '{6'b001000, 32'h5123_4567, 32'hDEAD_BEEF, 32'h0, 4'h5, 6'b001000, 1, 0};
        tbl[2] = '{6'b010000, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 4'h5, 6'b010000, 1, 0};
        tbl[3] = '{6'b000110, 32'h0000_0000, 32'hDEAD_BEEF, 32'h1234_5678, 4'h5, 6'b000000, 1, 0};
        tbl[4] = '{6'b000100, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h1234_5678, 4'h5, 6'b000100, 1, 0};
        tbl[5] = '{6'b000010, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h1234_5678, 4'h5, 6'b000010, 1, 0};
        tbl[6] = '{6'b000101, 32'h0000_0000, 32'hDEAD_BEEF, 32'h1234_5678, 4'h5, 6'b000010, 0, 1};
`ifdef ALU_ACC_FEEDBACK_EN
        tbl[7] = '{6'b100001, 32'hFFFF_FFFF, 32'h0000_0007, 32'h1234_5678, 4'h5, 6'b100000, 1, 0};
        tbl[8] = '{6'b110000, 32'hFFFF_FFFF, 32'h0000_0007, 32'h1234_5678, 4'h5, 6'b100000, 0, 1};
        tbl[9] = '{6'b000001, 32'hAAAA_AAAA, 32'h0000_0007, 32'h1234_5678, 4'h5, 6'b000001, 1, 0};
`else
        tbl[7] = '{6'b100001, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h1234_5678, 4'h5, 6'b000010, 0, 1};
        tbl[8] = '{6'b110000, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h1234_5678, 4'h5, 6'b000010, 0, 1};
        tbl[9] = '{6'b000001, 32'hAAAA_AAAA, 32'hDEAD_BEEF, 32'h1234_5678, 4'h5, 6'b000001, 1, 0};
`endif

        rst     = 1'b1;
        sw      = 32'h0;
        btn_raw = 6'b0;
        clear_mon();
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state
        chk_regs("reset", 32'h0, 32'h0, 4'h0, 6'b0);
        chk("reset.upd", {31'd0, upd}, 32'd0);
        chk("reset.err", {31'd0, err}, 32'd0);
        chk("reset.busy", {31'd0, busy}, 32'd0);

        // Reset during SETTLE discards the chord
        clear_mon();
        sw         = 32'hCAFE_F00D;
        btn_raw[5] = 1'b1;
        tick(10);
        chk("settle.busy", {31'd0, busy}, 32'd1);
        rst        = 1'b1;
        btn_raw    = 6'b0;
        tick(1);
        rst = 1'b0;
        chk("settle_rst.busy", {31'd0, busy}, 32'd0);
        tick(20);
        chk("settle_rst.a_out", a_out, 32'h0);
        chk("settle_rst.upd_cnt", upd_cnt, 32'd0);
        chk("settle_rst.busy_end", {31'd0, busy}, 32'd0);

        // Bouncing btn[4]: never stable long enough to register
        clear_mon();
        sw = 32'h7777_7777;
        for (int i = 0; i < 15; i++) begin
            btn_raw[4] = ~btn_raw[4];
            tick(2);
        end
        btn_raw = 6'b0;
        tick(10);
        chk("bounce.upd_cnt", upd_cnt, 32'd0);
        chk("bounce.busy_seen", {31'd0, busy_seen}, 32'd0);
        chk("bounce.b_out", b_out, 32'h0);

        // Table-driven presses and chords
        for (int v = 0; v < 10; v++) begin
            clear_mon();
            sw      = tbl[v].sw;
            btn_raw = tbl[v].btn;
            tick(20);
            btn_raw = 6'b0;
            sw      = ~tbl[v].sw;
            tick(20);
            chk_regs($sformatf("vec%0d", v), tbl[v].a, tbl[v].b, tbl[v].op, tbl[v].show);
            chk($sformatf("vec%0d.upd_cnt", v), upd_cnt, tbl[v].n_upd);
            chk($sformatf("vec%0d.err_cnt", v), err_cnt, tbl[v].n_err);
            chk($sformatf("vec%0d.strobe_cycle", v), first_strobe, STROBE_LAT);
            chk($sformatf("vec%0d.busy_end", v), {31'd0, busy}, 32'd0);
        end

        // Staggered chord: btn[2] then btn[1] three cycles later
        clear_mon();
        sw         = 32'h0;
        btn_raw[2] = 1'b1;
        tick(3);
        btn_raw[1] = 1'b1;
        tick(17);
        btn_raw = 6'b0;
        tick(20);
        chk_regs("stagger", tbl[9].a, 32'h1234_5678, 4'h5, 6'b000000);
        chk("stagger.upd_cnt", upd_cnt, 32'd1);
        chk("stagger.err_cnt", err_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Upstream front-end for the 32-bit ALU on the board.
- Debounces the six raw push buttons and classifies single presses and two-button chords.
- Latches operand A, operand B and the 4-bit opcode from the 32 slide switches.
- Drives the display-select code and issues a one-cycle update strobe so the ALU recomputes its result on a clean clock edge, not on a button edge.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a debounced button bit changes (5 ms at 100 MHz).
- CHORD_CYCLES, 2000000, maximum window for collecting a button chord after the first press.
- DATA_W, 32, operand width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sw  in  DATA_W  slide switches; bit 31 is the leftmost switch
- btn_raw  in  6  asynchronous push buttons; bit 5 is the leftmost button
- a_out  out  DATA_W  latched operand A
- b_out  out  DATA_W  latched operand B
- op_out  out  4  latched opcode
- show_mode  out  6  one-hot display select; 0 means show live switches
- upd  out  1  one-cycle strobe after any register or mode change
- err  out  1  one-cycle strobe on an unrecognised chord
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: a_out=0, b_out=0, op_out=0, show_mode=0, upd=0, err=0, busy=0. The FSM goes to IDLE. Synchronisers, debounced bits, counters and the chord mask all clear. A reset mid-chord discards the chord with no register update.
- Per button:
  - 2-flop synchroniser feeds a counter.
  - The counter increments while the synchronised value differs from the debounced bit, and clears when they agree.
  - When the count reaches DEBOUNCE_CYCLES-1, the debounced bit flips and the counter clears.
  - Latency from a stable raw edge to the debounced edge is DEBOUNCE_CYCLES+2 cycles.
- FSM, with db as the debounced button vector and mask as the accumulated chord:
  - IDLE: when db!=0, set mask=db, clear the chord timer, go to SETTLE.
  - SETTLE: each cycle mask|=db and the timer increments. When db==0 (quick release) or the timer reaches CHORD_CYCLES-1, go to ACT.
  - ACT: one cycle. Decode mask and sample sw in this same cycle. Updates land on the edge leaving ACT. Go to RELEASE.
  - RELEASE: wait for db==0, then go to IDLE. New presses here are ignored.
- Decode, applied on the edge leaving ACT:
  - 100000: a_out<=sw and show_mode<=100000.
  - 010000: b_out<=sw and show_mode<=010000.
  - 001000: op_out<=sw[31:28] and show_mode<=001000.
  - 000100, 000010, 000001: show_mode<=mask only.
  - 000110: show_mode<=000000.
  - Any other mask: no register change, err=1 for one cycle.
- upd is asserted for one cycle, coincident with the updated registers, on every valid decode, including mode-only decodes.
- upd and err are never high together.
- Switch changes outside ACT never affect the outputs.

Optional Feature:
- Macro ALU_ACC_FEEDBACK_EN.
- When defined:
  - Adds input port f_in (DATA_W), the ALU result.
  - Chord 100001 performs a_out<=f_in and show_mode<=100000, then upd.
  - This provides accumulator chaining, e.g. repeated increment.
- When undefined, there is no f_in port and 100001 is decoded as an error.

Decomposition:
- Package alu_ui_pkg holds:
  - FSM state enum (IDLE, SETTLE, ACT, RELEASE).
  - Chord mask constants: MASK_A, MASK_B, MASK_OP, MASK_SHOW_A, MASK_SHOW_B, MASK_SHOW_F, MASK_CLR, MASK_ACC.
  - OP_W=4.
- Sub-module btn_debounce (synchroniser plus counter, one bit), instantiated six times with a generate loop.

Test Plan (DEBOUNCE_CYCLES=4, CHORD_CYCLES=8):
- Reset → all outputs 0 and busy=0. Then assert rst during SETTLE → FSM returns to IDLE and a_out is unchanged.
- sw=32'hDEADBEEF, press btn[5] cleanly for 20 cycles → a_out=DEADBEEF, show_mode=100000, exactly one upd pulse, 6 cycles after the raw edge plus the SETTLE and ACT cycles.
- Raw btn[4] toggling every 2 cycles for 30 cycles → no debounced edge, no upd, b_out stays 0.
- sw[31:28]=4'b0101, press btn[3] → op_out=0101. Changing sw afterwards leaves op_out unchanged.
- Press btn[2], then btn[1] 3 cycles later, hold both → mask 000110 and show_mode=000000. Press btn[2] and btn[0] → err pulse and no register change.
- With ALU_ACC_FEEDBACK_EN: f_in=32'h00000007, chord 100001 → a_out=00000007 and upd=1. Without the macro, the same chord → err=1.
